// File: rtl/uart_pkg.sv
// uart_pkg: shared UART rate encoding, tick divisor math and receiver state encoding.
// Used by both the receive and transmit sides of the UART.
package uart_pkg;
    localparam int BAUD_2400  = 2400;
    localparam int BAUD_4800  = 4800;
    localparam int BAUD_9600  = 9600;
    localparam int BAUD_19200 = 19200;
    localparam int OSR        = 16;
    localparam logic [1:0] SEL_2400  = 2'b00;
    localparam logic [1:0] SEL_4800  = 2'b01;
    localparam logic [1:0] SEL_9600  = 2'b10;
    localparam logic [1:0] SEL_19200 = 2'b11;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    function automatic int baud_of(input logic [1:0] sel);
        return sel == SEL_2400 ? BAUD_2400 :
               sel == SEL_4800 ? BAUD_4800 :
               sel == SEL_9600 ? BAUD_9600 : BAUD_19200;
    endfunction
    // Truncating divide: the residual rate error is well inside the mid-bit sampling margin.
    function automatic logic [15:0] tick_div(input int freq, input logic [1:0] sel);
        return 16'(freq / (OSR * baud_of(sel)));
    endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: oversampling tick generator; latches the divisor while cleared and
// then runs free, pulsing o_tick on the last count of each period.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int FREQ = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic       i_clear,
    input  logic [1:0] i_baud_sel,
    output logic       o_tick
);
    logic [15:0] r_div;
    logic [15:0] r_cnt;
    assign o_tick = !i_clear && r_cnt == r_div - 16'd1;
    always_ff @(posedge i_clk or posedge i_arst)
        if (i_arst) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_div <= tick_div(FREQ, i_baud_sel);
            r_cnt <= '0;
        end else begin
            r_cnt <= o_tick ? '0 : r_cnt + 16'd1;
        end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first receiver with 16x oversampling, mid-bit start validation,
// one-cycle byte strobe and framing-error strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FREQ       = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic       i_rx,
    input  logic [1:0] i_baud_sel,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_busy
);
    logic [1:0] r_sync;
    logic       r_armed;
    logic [3:0] r_scnt;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    state_t     r_state;
    logic       w_rx_s;
    logic       w_tick;
    logic       w_clear;
    logic       w_mid;
    logic       w_last;

    assign w_rx_s  = r_sync[1];
    assign w_clear = r_state == IDLE;
    assign w_mid   = w_tick && r_scnt == 4'(OVERSAMPLE / 2 - 1);
    assign w_last  = w_tick && r_scnt == 4'(OVERSAMPLE - 1);

    always_ff @(posedge i_clk or posedge i_arst)
        if (i_arst)
            r_sync <= 2'b11;
        else
            r_sync <= {r_sync[0], i_rx};

    uart_tick_gen #(.FREQ(FREQ)) u_tick (
        .i_clk      (i_clk),
        .i_arst     (i_arst),
        .i_clear    (w_clear),
        .i_baud_sel (i_baud_sel),
        .o_tick     (w_tick)
    );

    always_ff @(posedge i_clk or posedge i_arst)
        if (i_arst) begin
            r_state     <= IDLE;
            r_armed     <= 1'b0;
            r_scnt      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_scnt  <= '0;
                    // Tracks rx_s, so a line still low after a frame (break) never re-arms.
                    r_armed <= w_rx_s;
                    if (!w_rx_s && r_armed) begin
                        r_state <= START;
                        o_busy  <= 1'b1;
                    end
                end
                START: if (w_tick) begin
                    r_scnt <= w_mid ? '0 : r_scnt + 4'd1;
                    if (w_mid) begin
                        r_bit   <= '0;
                        r_state <= w_rx_s ? IDLE : DATA;
                        o_busy  <= !w_rx_s;
                    end
                end
                DATA: if (w_tick) begin
                    r_scnt <= w_last ? '0 : r_scnt + 4'd1;
                    if (w_last) begin
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7)
                            r_state <= STOP;
                    end
                end
                STOP: if (w_tick) begin
                    r_scnt <= w_last ? '0 : r_scnt + 4'd1;
                    if (w_last) begin
                        if (w_rx_s)
                            o_rx_data <= r_shift;
                        o_rx_valid  <= w_rx_s;
                        o_frame_err <= !w_rx_s;
                        r_state     <= IDLE;
                        o_busy      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at a 1 MHz clock, so divisors are 26/13/6/3.
module tb_uart_rx;
    import uart_pkg::*;
    logic       clk = 1'b0;
    logic       arst;
    logic       rx;
    logic [1:0] baud_sel;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, busy;
    int checks = 0, errors = 0;
    int cyc = 0, nv = 0, nf = 0, nb = 0;
    int t_v = 0, t_f = 0, t_rise = 0, t_fall = 0;
    logic p_busy = 1'b0;
    int divs [4] = '{26, 13, 6, 3};
    int c0, v0, f0, b0, g0;

    uart_rx #(.FREQ(1_000_000)) dut (
        .i_clk       (clk),
        .i_arst      (arst),
        .i_rx        (rx),
        .i_baud_sel  (baud_sel),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!arst) begin
            if (rx_valid) begin nv++; t_v = cyc; end
            if (frame_err) begin nf++; t_f = cyc; end
            if (busy) nb++;
            if (busy && !p_busy) t_rise = cyc;
            if (!busy && p_busy) t_fall = cyc;
        end
        p_busy = busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nbits of {stop, d, start}; baud_sel switches to alt after the start bit.
    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic [1:0] alt,
                        input logic stop, input int nbits, output int t0);
        logic [9:0] f;
        int bl;
        f = {stop, d, 1'b0};
        bl = 16 * divs[s];
        baud_sel = s;
        t0 = cyc;
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            repeat (bl) @(negedge clk);
            baud_sel = alt;
        end
    endtask

    initial begin
        rx = 1'b1;
        arst = 1'b1;
        baud_sel = 2'b10;
        idle(3);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        arst = 1'b0;
        idle(2000);
        chk("idle_busy", nb, 0);
        chk("idle_valid", nv, 0);
        chk("idle_ferr", nf, 0);

        chk("div_2400", tick_div(50_000_000, 2'b00), 1302);
        chk("div_4800", tick_div(50_000_000, 2'b01), 651);
        chk("div_9600", tick_div(50_000_000, 2'b10), 325);
        chk("div_19200", tick_div(50_000_000, 2'b11), 162);

        v0 = nv; f0 = nf;
        send(8'hA5, 2'b10, 2'b11, 1'b1, 10, c0);
        idle(20);
        chk("good_cnt", nv - v0, 1);
        chk("good_when", t_v, c0 + 3 + 152 * 6);
        chk("good_data", rx_data, 8'hA5);
        chk("good_ferr", nf - f0, 0);
        chk("busy_rise", t_rise, c0 + 3);
        chk("busy_fall", t_fall, c0 + 3 + 152 * 6);

        for (int s = 0; s < 4; s++) begin
            v0 = nv;
            send(8'h3C, 2'(s), 2'(s), 1'b1, 10, c0);
            idle(4);
            chk($sformatf("rate%0d_data", s), rx_data, 8'h3C);
            chk($sformatf("rate%0d_cnt", s), nv - v0, 1);
            chk($sformatf("rate%0d_when", s), t_v, c0 + 3 + 152 * divs[s]);
        end

        v0 = nv;
        send(8'h00, 2'b11, 2'b11, 1'b1, 10, c0);
        chk("b2b_first", rx_data, 8'h00);
        send(8'hFF, 2'b11, 2'b11, 1'b1, 10, c0);
        idle(4);
        chk("b2b_cnt", nv - v0, 2);
        chk("b2b_data", rx_data, 8'hFF);

        v0 = nv; f0 = nf;
        baud_sel = 2'b10;
        g0 = cyc;
        rx = 1'b0;
        idle(18);
        rx = 1'b1;
        idle(200);
        chk("glitch_valid", nv - v0, 0);
        chk("glitch_ferr", nf - f0, 0);
        chk("glitch_busy", busy, 0);
        chk("glitch_abort", t_fall, g0 + 51);
        send(8'h55, 2'b10, 2'b10, 1'b1, 10, c0);
        idle(4);
        chk("after_glitch", rx_data, 8'h55);
        chk("after_glitch_cnt", nv - v0, 1);

        v0 = nv; f0 = nf;
        send(8'h81, 2'b10, 2'b10, 1'b0, 10, c0);
        b0 = nb;
        idle(20 * 96);
        chk("ferr_cnt", nf - f0, 1);
        chk("ferr_when", t_f, c0 + 3 + 152 * 6);
        chk("ferr_valid", nv - v0, 0);
        chk("ferr_data", rx_data, 8'h55);
        chk("break_busy", nb - b0, 0);
        rx = 1'b1;
        idle(100);
        chk("break_release", nf - f0, 1);
        chk("break_idle", busy, 0);

        v0 = nv; f0 = nf;
        send(8'h96, 2'b10, 2'b10, 1'b1, 4, c0);
        rx = 1'b0;
        idle(48);
        arst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", rx_data, 8'h00);
        chk("mid_rst_valid", rx_valid, 0);
        rx = 1'b1;
        idle(3);
        arst = 1'b0;
        idle(1500);
        chk("mid_rst_nostrobe", (nv - v0) + (nf - f0), 0);
        send(8'h96, 2'b10, 2'b10, 1'b1, 10, c0);
        idle(4);
        chk("post_rst_data", rx_data, 8'h96);
        chk("post_rst_cnt", nv - v0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
